data_memory_ctrl: RTL and testbench

//   Parametrised data memory with a valid/ready request/response handshake.

---
 rtl/data_mem_pkg.sv | 30 +++
 rtl/data_memory_ctrl_if.sv | 29 ++
 rtl/dmem_sram_array.sv | 54 +++++
 rtl/data_memory_ctrl.sv | 176 +++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory controller: access modes, FSM states
// and the lane geometry helpers derived from the word width.
package data_mem_pkg;

  typedef enum logic [1:0] {
    MODE_WORD   = 2'b00,
    MODE_BYTE_U = 2'b01,
    MODE_BYTE_S = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  function automatic int lanes_of(int data_w);
    return data_w / 8;
  endfunction

  // Kept at least 1 bit wide so an 8-bit build still has a legal lane field.
  function automatic int lane_sel_w(int data_w);
    return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
  endfunction

  localparam int LANES_PER_WORD = lanes_of(16);
  localparam int LANE_SEL_W     = lane_sel_w(16);

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface data_memory_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  // A request transfers on a rising edge where req_valid && req_ready; a response
  // transfers on a rising edge where rsp_valid && rsp_ready. rsp_* stay stable
  // while rsp_valid is high and rsp_ready is low; req_* are ignored while req_ready is low.
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_mode;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_mode, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_mode, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_sram_array.sv
// DEPTH x DATA_W storage with per-byte-lane write enables and a registered read port.
// With DMEM_PARITY_EN defined, one even-parity bit per lane is stored and checked on read.
module dmem_sram_array #(
  parameter int  DATA_W = 16,
  parameter int  DEPTH  = 2048,
  localparam int LANES  = DATA_W / 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [LANES-1:0]  lane_we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [LANES-1:0]  par_err
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_we[l]) mem_q[idx][l*8 +: 8] <= wdata[l*8 +: 8];
      end
    end
    if (en && !we) rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

`ifdef DMEM_PARITY_EN
  logic [LANES-1:0] par_mem_q [DEPTH];
  logic [LANES-1:0] rpar_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_we[l]) par_mem_q[idx][l] <= ^wdata[l*8 +: 8];
      end
    end
    if (en && !we) rpar_q <= par_mem_q[idx];
  end

  // Even parity: data bits plus stored bit must XOR to zero.
  always_comb begin
    par_err = '0;
    for (int l = 0; l < LANES; l++) par_err[l] = ^{rdata_q[l*8 +: 8], rpar_q[l]};
  end
`else
  assign par_err = '0;
`endif

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: valid/ready request/response front end, fault checks,
// wait-state sequencing and byte extension. Optional parity via DMEM_PARITY_EN.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 2048,
  parameter int WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst,
  data_memory_ctrl_if.slave  bus,
  output state_e             dbg_state
);
  localparam int LANES = lanes_of(DATA_W);
  localparam int LSW   = lane_sel_w(DATA_W);
  localparam int SHIFT = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              wr_q, wr_d;
  mode_e             mode_q, mode_d;
  logic [LSW-1:0]    lane_q, lane_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_rd_q, rsp_rd_d;

  logic              req_ready, req_fire, req_fault;
  mode_e             req_mode;
  logic [ADDR_W-1:0] req_idx;
  logic [LSW-1:0]    req_lane;

  logic              arr_en;
  logic [LANES-1:0]  lane_mask;
  logic [DATA_W-1:0] arr_wdata, arr_rdata, rdata_ext;
  logic [LANES-1:0]  arr_par_err;
  logic [7:0]        rd_byte;

  assign req_ready = ready_q & ~rst;
  assign req_fire  = bus.req_valid & req_ready;
  assign req_mode  = mode_e'(bus.req_mode);
  assign req_idx   = bus.req_addr >> SHIFT;
  assign req_lane  = LSW'(bus.req_addr) & LSW'(LANES - 1);
  assign req_fault = (req_mode == MODE_RSVD) ||
                     (req_mode == MODE_WORD && req_lane != '0) ||
                     (33'(req_idx) >= 33'(DEPTH));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    wr_d        = wr_q;
    mode_d      = mode_q;
    lane_d      = lane_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rd_d    = rsp_rd_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          wr_d    = bus.req_wr;
          mode_d  = req_mode;
          lane_d  = req_lane;
          idx_d   = IDX_W'(req_idx);
          wdata_d = bus.req_wdata;
          ready_d = 1'b0;
          if (req_fault) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rd_d    = 1'b0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rd_d    = ~wr_q;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rd_d    = 1'b0;
          ready_d     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      wr_q        <= 1'b0;
      mode_q      <= MODE_WORD;
      lane_q      <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      wr_q        <= wr_d;
      mode_q      <= mode_d;
      lane_q      <= lane_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // Gated by rst so a write caught by reset on its access edge never lands.
  assign arr_en    = (state_q == S_WAIT) && (cnt_q == 4'd0) && !rst;
  assign lane_mask = (mode_q == MODE_WORD) ? '1 : (LANES'(1) << lane_q);
  assign arr_wdata = (mode_q == MODE_WORD) ? wdata_q : {LANES{wdata_q[7:0]}};

  dmem_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .en      (arr_en),
    .we      (wr_q),
    .lane_we (lane_mask),
    .idx     (idx_q),
    .wdata   (arr_wdata),
    .rdata   (arr_rdata),
    .par_err (arr_par_err)
  );

  // The array's read register holds still through RESP, so extension can stay combinational.
  assign rd_byte = arr_rdata[lane_q*8 +: 8];

  always_comb begin
    rdata_ext = '0;
    if (rsp_rd_q) begin
      case (mode_q)
        MODE_WORD:   rdata_ext = arr_rdata;
        MODE_BYTE_U: rdata_ext = DATA_W'(rd_byte);
        MODE_BYTE_S: rdata_ext = DATA_W'($signed(rd_byte));
        default:     rdata_ext = '0;
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_ext;
  assign bus.rsp_err   = rsp_err_q | (rsp_rd_q & |(arr_par_err & lane_mask));
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed vector table, random traffic against a
// byte-array reference model, wait-state/back-pressure and mid-operation reset sequences.
module tb_data_memory_ctrl;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(16)) if0 ();
  data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(16)) if3 ();
  state_e dbg0, dbg3;

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(2048), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave), .dbg_state(dbg0));
  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(2048), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave), .dbg_state(dbg3));

  int checks = 0;
  int failures = 0;

  // Reference model: plain byte-addressed memory, one per DUT (0 = dut0, 1 = dut3).
  logic [7:0]  mdl [2][4096];
  logic [16:0] exp_q[$];

  typedef struct {
    string       name;
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  mode;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model_access(input int sel, input logic wr, input logic [15:0] addr,
                                               input logic [1:0] mode, input logic [15:0] wdata);
    logic [11:0] base;
    logic [7:0]  b;
    if (mode == 2'b11 || (mode == 2'b00 && addr[0]) || addr >= 16'h1000) return {1'b1, 16'h0};
    base = 12'(addr) & 12'hFFE;
    if (wr) begin
      if (mode == 2'b00) begin
        mdl[sel][base]        = wdata[7:0];
        mdl[sel][base + 12'd1] = wdata[15:8];
      end else begin
        mdl[sel][12'(addr)] = wdata[7:0];
      end
      return 17'h0;
    end
    if (mode == 2'b00) return {1'b0, mdl[sel][base + 12'd1], mdl[sel][base]};
    b = mdl[sel][12'(addr)];
    if (mode == 2'b01) return {9'h0, b};
    return {1'b0, {8{b[7]}}, b};
  endfunction

  function automatic logic g_req_ready(input int sel);
    return (sel == 0) ? if0.req_ready : if3.req_ready;
  endfunction
  function automatic logic g_rsp_valid(input int sel);
    return (sel == 0) ? if0.rsp_valid : if3.rsp_valid;
  endfunction
  function automatic logic [15:0] g_rsp_rdata(input int sel);
    return (sel == 0) ? if0.rsp_rdata : if3.rsp_rdata;
  endfunction
  function automatic logic g_rsp_err(input int sel);
    return (sel == 0) ? if0.rsp_err : if3.rsp_err;
  endfunction

  task automatic set_req(input int sel, input logic v, input logic wr, input logic [15:0] a,
                         input logic [1:0] m, input logic [15:0] d);
    if (sel == 0) begin
      if0.req_valid = v; if0.req_wr = wr; if0.req_addr = a; if0.req_mode = m; if0.req_wdata = d;
    end else begin
      if3.req_valid = v; if3.req_wr = wr; if3.req_addr = a; if3.req_mode = m; if3.req_wdata = d;
    end
  endtask

  task automatic set_rsp_ready(input int sel, input logic r);
    if (sel == 0) if0.rsp_ready = r;
    else          if3.rsp_ready = r;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_txn(input int sel, input logic wr, input logic [15:0] addr, input logic [1:0] mode,
                        input logic [15:0] wdata, input int hold, input logic [15:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input string name);
    int n;
    int lat;
    n = 0;
    while (!g_req_ready(sel) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_req_ready"}, 32'(g_req_ready(sel)), 32'd1);
    set_req(sel, 1'b1, wr, addr, mode, wdata);
    @(posedge clk); #1;
    set_req(sel, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    lat = 0;
    while (!g_rsp_valid(sel) && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "_rsp_valid"}, 32'(g_rsp_valid(sel)), 32'd1);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_rdata"}, 32'(g_rsp_rdata(sel)), 32'(exp_rdata));
    check({name, "_err"}, 32'(g_rsp_err(sel)), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({name, "_hold_valid"}, 32'(g_rsp_valid(sel)), 32'd1);
      check({name, "_hold_rdata"}, 32'(g_rsp_rdata(sel)), 32'(exp_rdata));
      check({name, "_hold_err"}, 32'(g_rsp_err(sel)), 32'(exp_err));
      check({name, "_hold_ready"}, 32'(g_req_ready(sel)), 32'd0);
    end
    set_rsp_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_rsp_ready(sel, 1'b0);
    check({name, "_rsp_drop"}, 32'(g_rsp_valid(sel)), 32'd0);
    check({name, "_ready_back"}, 32'(g_req_ready(sel)), 32'd1);
  endtask

  task automatic add_vec(input string n, input logic wr, input logic [15:0] a, input logic [1:0] m,
                         input logic [15:0] d, input logic [15:0] er, input logic ee, input int el);
    vec_t v;
    v.name = n; v.wr = wr; v.addr = a; v.mode = m; v.wdata = d;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [16:0] exp;
    logic        r_wr;
    logic [15:0] r_addr, r_wdata;
    logic [1:0]  r_mode;

    set_req(0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    set_rsp_ready(0, 1'b0);
    set_rsp_ready(1, 1'b0);

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready0", 32'(if0.req_ready), 32'd0);
    check("rst_req_ready3", 32'(if3.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(if0.req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(if0.rsp_valid), 32'd0);
    check("post_rst_rdata", 32'(if0.rsp_rdata), 32'd0);
    check("post_rst_err", 32'(if0.rsp_err), 32'd0);
    check("post_rst_state", 32'(dbg0), 32'(S_IDLE));
    @(posedge clk); #1;

    // Known contents for the low 64 words.
    for (int i = 0; i < 64; i++) begin
      void'(model_access(0, 1'b1, 16'(2 * i), 2'b00, 16'h1000 + 16'(i)));
      do_txn(0, 1'b1, 16'(2 * i), 2'b00, 16'h1000 + 16'(i), 0, 16'h0, 1'b0, 1, "init");
    end

    // Directed vector table (WAIT_STATES=0).
    add_vec("t1_wr",       1'b1, 16'h0010, 2'b00, 16'hBEEF, 16'h0000, 1'b0, 1);
    add_vec("t1_rd",       1'b0, 16'h0010, 2'b00, 16'h0000, 16'hBEEF, 1'b0, 1);
    add_vec("t2_bwr",      1'b1, 16'h0011, 2'b01, 16'h0012, 16'h0000, 1'b0, 1);
    add_vec("t2_rd",       1'b0, 16'h0010, 2'b00, 16'h0000, 16'h12EF, 1'b0, 1);
    add_vec("t2_sext",     1'b0, 16'h0010, 2'b10, 16'h0000, 16'hFFEF, 1'b0, 1);
    add_vec("t2_zext",     1'b0, 16'h0010, 2'b01, 16'h0000, 16'h00EF, 1'b0, 1);
    add_vec("t2_hi_sext",  1'b0, 16'h0011, 2'b10, 16'h0000, 16'h0012, 1'b0, 1);
    add_vec("t3_unal",     1'b0, 16'h0011, 2'b00, 16'h0000, 16'h0000, 1'b1, 0);
    add_vec("t3_rsvd",     1'b0, 16'h0000, 2'b11, 16'h0000, 16'h0000, 1'b1, 0);
    add_vec("t3_rsvd_wr",  1'b1, 16'h0000, 2'b11, 16'hDEAD, 16'h0000, 1'b1, 0);
    add_vec("t3_range",    1'b0, 16'h1000, 2'b00, 16'h0000, 16'h0000, 1'b1, 0);
    add_vec("t3_range_wr", 1'b1, 16'h1000, 2'b00, 16'h1234, 16'h0000, 1'b1, 0);
    add_vec("t3_unal_wr",  1'b1, 16'h0011, 2'b00, 16'h5678, 16'h0000, 1'b1, 0);
    add_vec("t3_reread",   1'b0, 16'h0010, 2'b00, 16'h0000, 16'h12EF, 1'b0, 1);
    add_vec("t3_reread0",  1'b0, 16'h0000, 2'b00, 16'h0000, 16'h1000, 1'b0, 1);
    add_vec("t3_last_wr",  1'b1, 16'h0FFE, 2'b00, 16'hCAFE, 16'h0000, 1'b0, 1);
    add_vec("t3_last_rd",  1'b0, 16'h0FFE, 2'b00, 16'h0000, 16'hCAFE, 1'b0, 1);
    foreach (vecs[i]) begin
      void'(model_access(0, vecs[i].wr, vecs[i].addr, vecs[i].mode, vecs[i].wdata));
      do_txn(0, vecs[i].wr, vecs[i].addr, vecs[i].mode, vecs[i].wdata, 0,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].name);
    end

    // Random traffic against the reference model with random back-pressure.
    for (int i = 0; i < 200; i++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_mode  = 2'($urandom_range(0, 3));
      r_wdata = 16'($urandom);
      r_addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'h1000, 16'hFFFF))
                                            : 16'($urandom_range(0, 127));
      exp_q.push_back(model_access(0, r_wr, r_addr, r_mode, r_wdata));
      exp = exp_q.pop_front();
      do_txn(0, r_wr, r_addr, r_mode, r_wdata, $urandom_range(0, 2), exp[15:0], exp[16],
             exp[16] ? 0 : 1, "rand");
    end

    // WAIT_STATES=3: latency 4 and a 5-cycle stall on rsp_ready.
    void'(model_access(1, 1'b1, 16'h0020, 2'b00, 16'h5555));
    do_txn(1, 1'b1, 16'h0020, 2'b00, 16'h5555, 0, 16'h0000, 1'b0, 4, "t4_init");
    do_txn(1, 1'b0, 16'h0020, 2'b00, 16'h0000, 5, 16'h5555, 1'b0, 4, "t4_rd");
    do_txn(1, 1'b0, 16'h0021, 2'b10, 16'h0000, 2, 16'h0055, 1'b0, 4, "t4_byte");

    // Reset while a write is still counting down its wait states.
    set_req(1, 1'b1, 1'b1, 16'h0020, 2'b00, 16'hAAAA);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    check("t5_in_wait", 32'(dbg3), 32'(S_WAIT));
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_ready", 32'(if3.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("t5_rsp_valid", 32'(if3.rsp_valid), 32'd0);
    check("t5_req_ready", 32'(if3.req_ready), 32'd1);
    check("t5_state", 32'(dbg3), 32'(S_IDLE));
    @(posedge clk); #1;
    do_txn(1, 1'b0, 16'h0020, 2'b00, 16'h0000, 0, 16'h5555, 1'b0, 4, "t5_old");
    do_txn(0, 1'b0, 16'h0010, 2'b00, 16'h0000, 0, 16'h12EF, 1'b0, 1, "t5_keep0");

`ifdef DMEM_PARITY_EN
    // Corrupt one stored bit behind the parity and read it back.
    void'(model_access(0, 1'b1, 16'h0030, 2'b00, 16'h0F0F));
    do_txn(0, 1'b1, 16'h0030, 2'b00, 16'h0F0F, 0, 16'h0000, 1'b0, 1, "t6_wr");
    dut0.u_array.mem_q[24][0] = ~dut0.u_array.mem_q[24][0];
    do_txn(0, 1'b0, 16'h0030, 2'b00, 16'h0000, 0, 16'h0F0E, 1'b1, 1, "t6_par");
    do_txn(0, 1'b0, 16'h0031, 2'b01, 16'h0000, 0, 16'h000F, 1'b0, 1, "t6_other_lane");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
